// File: rtl/ecg_group_unpacker_if.sv
// ecg_group_unpacker_if
//   Handshake bundle for the ECG group unpacker.
//   Parser side : grp_valid, grp_data -> unpacker; grp_ready <- unpacker.
//   Output side : out_valid, out_data, out_comp_idx, out_ecg_idx, out_active
//                 <- unpacker; out_ready -> unpacker.
//   modport slave  : the unpacker itself.
//   modport master : the surrounding parser/downstream environment.
interface ecg_group_unpacker_if #(
  parameter int unsigned GRP_W = 16
);
  logic             grp_valid;
  logic [GRP_W-1:0] grp_data;
  logic             grp_ready;
  logic             out_valid;
  logic             out_ready;
  logic [GRP_W-1:0] out_data;
  logic [1:0]       out_comp_idx;
  logic [1:0]       out_ecg_idx;
  logic             out_active;

  modport slave (
    input  grp_valid, grp_data, out_ready,
    output grp_ready, out_valid, out_data, out_comp_idx, out_ecg_idx, out_active
  );

  modport master (
    output grp_valid, grp_data, out_ready,
    input  grp_ready, out_valid, out_data, out_comp_idx, out_ecg_idx, out_active
  );
endinterface

// File: rtl/ecg_group_unpacker.sv
// ecg_group_unpacker
//   Walks the ECG slots of one block (component-major, 4 ECGs per component),
//   fetches one parsed group from the parser for every active slot and hands it
//   downstream tagged with component/ECG index. One beat in flight at a time.
//   Ports:
//     clk, rst_n       clock, synchronous active-low reset
//     start            begin a block (ignored while busy)
//     sub_sample_info  0=4:4:4 1=4:2:2 2=4:2:0 3=reserved(4:4:4), latched on start
//     comp_skip        per-component skip flags, latched on start
//     bus (slave)      grp_* parser handshake, out_* downstream beat
//     busy             block in progress
//     done             one-cycle pulse after the last slot
//   Build option: define ECG_ZERO_EMIT_EN to emit a zero beat (out_active=0)
//   for every inactive slot; otherwise inactive slots are skipped silently.
module ecg_group_unpacker #(
  parameter int unsigned GRP_W    = 16,
  parameter int unsigned NUM_COMP = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          sub_sample_info,
  input  logic [NUM_COMP-1:0] comp_skip,
  ecg_group_unpacker_if.slave bus,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {IDLE, EVAL, FETCH, HOLD, DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          ssi_q;
  logic [NUM_COMP-1:0] skip_q;
  logic [1:0]          comp_q, ecg_q;
  logic [3:0]          skip_ext;
  logic                slot_active, last_slot;
  logic                slot_adv, load_grp, load_zero;
  logic [GRP_W-1:0]    data_q;
  logic [1:0]          tag_comp_q, tag_ecg_q;
  logic                active_q;

  // Activity of the current slot from the latched configuration.
  always_comb begin
    skip_ext                 = '0;
    skip_ext[NUM_COMP-1:0]   = skip_q;
    slot_active              = 1'b1;
    if (skip_ext[comp_q]) begin
      slot_active = 1'b0;
    end else if (comp_q != 2'd0) begin
      case (ssi_q)
        2'd1:    if (ecg_q[1]) slot_active = 1'b0;
        2'd2:    if (ecg_q != 2'd0) slot_active = 1'b0;
        default: ;
      endcase
    end
  end

  assign last_slot = (comp_q == 2'(NUM_COMP - 1)) && (ecg_q == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    slot_adv  = 1'b0;
    load_grp  = 1'b0;
    load_zero = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = EVAL;
      EVAL: begin
        if (slot_active) begin
          state_d = FETCH;
        end else begin
`ifdef ECG_ZERO_EMIT_EN
          load_zero = 1'b1;
          state_d   = HOLD;
`else
          if (last_slot) begin
            state_d = DONE;
          end else begin
            slot_adv = 1'b1;
            state_d  = EVAL;
          end
`endif
        end
      end
      FETCH: if (bus.grp_valid) begin
        load_grp = 1'b1;
        state_d  = HOLD;
      end
      HOLD: if (bus.out_ready) begin
        if (last_slot) begin
          state_d = DONE;
        end else begin
          slot_adv = 1'b1;
          state_d  = EVAL;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Configuration and slot counter; config only changes on an accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ssi_q  <= '0;
      skip_q <= '0;
      comp_q <= '0;
      ecg_q  <= '0;
    end else if (state_q == IDLE && start) begin
      ssi_q  <= sub_sample_info;
      skip_q <= comp_skip;
      comp_q <= '0;
      ecg_q  <= '0;
    end else if (slot_adv) begin
      ecg_q <= ecg_q + 2'd1;
      if (ecg_q == 2'd3) comp_q <= comp_q + 2'd1;
    end
  end

  // Output beat register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q     <= '0;
      tag_comp_q <= '0;
      tag_ecg_q  <= '0;
      active_q   <= 1'b0;
    end else if (load_grp) begin
      data_q     <= bus.grp_data;
      tag_comp_q <= comp_q;
      tag_ecg_q  <= ecg_q;
      active_q   <= 1'b1;
    end else if (load_zero) begin
      data_q     <= '0;
      tag_comp_q <= comp_q;
      tag_ecg_q  <= ecg_q;
      active_q   <= 1'b0;
    end
  end

  assign bus.grp_ready    = (state_q == FETCH);
  assign bus.out_valid    = (state_q == HOLD);
  assign bus.out_data     = data_q;
  assign bus.out_comp_idx = tag_comp_q;
  assign bus.out_ecg_idx  = tag_ecg_q;
  assign bus.out_active   = active_q;
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == DONE);

endmodule

// File: tb/tb_ecg_group_unpacker.sv
// tb_ecg_group_unpacker
//   Table of block configurations with hand-computed slot activity masks
//   (bit c*4+e = slot active), replayed against the unpacker, plus a
//   mid-block reset sequence. Works for either build of ECG_ZERO_EMIT_EN.
module tb_ecg_group_unpacker;
  localparam int unsigned GRP_W    = 16;
  localparam int unsigned NUM_COMP = 3;
  localparam int          NSLOT    = 12;
`ifdef ECG_ZERO_EMIT_EN
  localparam bit ZERO_EMIT = 1'b1;
`else
  localparam bit ZERO_EMIT = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] ssi   = '0;
  logic [2:0] skip  = '0;
  logic       busy, done;

  ecg_group_unpacker_if #(.GRP_W(GRP_W)) bus ();

  ecg_group_unpacker #(.GRP_W(GRP_W), .NUM_COMP(NUM_COMP)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .sub_sample_info (ssi),
    .comp_skip       (skip),
    .bus             (bus),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  ssi;
    logic [2:0]  skip;
    logic [11:0] mask;        // expected slot activity
    bit          rand_stall;  // random parser/downstream back-pressure
    int          stall_slot;  // hold out_ready low 5 cycles on this slot (-1 none)
    int          restart_at;  // re-pulse start at this loop cycle (-1 none)
    bit          done_start;  // pulse start during the DONE cycle
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int next_emit(input logic [11:0] m, input int from);
    for (int s = from; s < NSLOT; s++)
      if (m[s] || ZERO_EMIT) return s;
    return NSLOT;
  endfunction

  task automatic run_block(input vec_t v, input logic [15:0] base);
    int exp_slot, act_n, beats, hs, dones, stall_left, exp_beats;
    logic        exp_act;
    logic [15:0] exp_data;
    exp_beats  = ZERO_EMIT ? NSLOT : $countones(v.mask);
    exp_slot   = next_emit(v.mask, 0);
    act_n      = 0;
    beats      = 0;
    hs         = 0;
    dones      = 0;
    stall_left = 5;
    @(negedge clk);
    ssi   = v.ssi;
    skip  = v.skip;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int cyc = 0; cyc < 400; cyc++) begin
      start = (cyc == v.restart_at) || (v.done_start && done);
      if (cyc == v.restart_at) begin
        ssi  = 2'd2;
        skip = 3'b111;
      end
      bus.grp_valid = v.rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.grp_data  = base + 16'(hs);
      bus.out_ready = v.rand_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      exp_act  = (exp_slot < NSLOT) ? v.mask[exp_slot] : 1'b0;
      exp_data = exp_act ? base + 16'(act_n) : 16'h0;
      if (bus.out_valid && exp_slot == v.stall_slot && stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
        check("stall_out_data", bus.out_data, exp_data);
        check("stall_tags", {bus.out_comp_idx, bus.out_ecg_idx},
              {2'(exp_slot / 4), 2'(exp_slot % 4)});
        check("stall_grp_ready", bus.grp_ready, 0);
      end
      if (bus.grp_ready) check("grp_ready_vs_out_valid", bus.out_valid, 0);
      if (bus.out_valid && bus.out_ready) begin
        beats++;
        if (exp_slot >= NSLOT) begin
          check("beat_count_overflow", beats, exp_beats);
        end else begin
          check("beat_data", bus.out_data, exp_data);
          check("beat_tags", {bus.out_comp_idx, bus.out_ecg_idx, bus.out_active},
                {2'(exp_slot / 4), 2'(exp_slot % 4), exp_act});
          if (exp_act) act_n++;
          exp_slot = next_emit(v.mask, exp_slot + 1);
        end
      end
      if (bus.grp_ready && bus.grp_valid) hs++;
      if (done) dones++;
      @(negedge clk);
      if (dones > 0 && !done) break;
    end
    start = 1'b0;
    check("beats", beats, exp_beats);
    check("grp_handshakes", hs, $countones(v.mask));
    check("done_pulses", dones, 1);
    check("all_slots_seen", exp_slot, NSLOT);
    check("busy_after_done", busy, 0);
    @(negedge clk);
    check("idle_stays_idle", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_grp_ready"}, bus.grp_ready, 0);
    check({tag, "_out"},       {bus.out_valid, bus.out_active, bus.out_comp_idx,
                                bus.out_ecg_idx, bus.out_data}, 0);
  endtask

  initial begin
    int hs;
    //          ssi   skip    mask    rnd stall rst  dstart
    vecs[0] = '{2'd0, 3'b000, 12'hFFF, 0, -1, -1, 0};  // T1
    vecs[1] = '{2'd1, 3'b000, 12'h33F, 0, -1, -1, 0};  // T2
    vecs[2] = '{2'd2, 3'b010, 12'h10F, 0, -1, -1, 0};  // T3
    vecs[3] = '{2'd0, 3'b000, 12'hFFF, 0,  3, -1, 0};  // T4
    vecs[4] = '{2'd0, 3'b000, 12'hFFF, 0, -1, 10, 0};  // T5
    vecs[5] = '{2'd3, 3'b000, 12'hFFF, 1, -1, -1, 0};
    vecs[6] = '{2'd0, 3'b111, 12'h000, 0, -1, -1, 1};
    vecs[7] = '{2'd2, 3'b000, 12'h11F, 1, -1, -1, 0};
    vecs[8] = '{2'd1, 3'b001, 12'h330, 1, -1, -1, 1};

    bus.grp_valid = 1'b0;
    bus.grp_data  = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_block(vecs[i], 16'(i * 256));

    // T6: reset while waiting in FETCH for slot 5
    @(negedge clk);
    ssi   = 2'd0;
    skip  = 3'b000;
    start = 1'b1;
    @(negedge clk);
    start         = 1'b0;
    bus.out_ready = 1'b1;
    hs = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      bus.grp_valid = (hs != 5);
      bus.grp_data  = 16'h5000 + 16'(hs);
      if (bus.grp_ready && hs == 5) break;
      if (bus.grp_ready && bus.grp_valid) hs++;
      @(negedge clk);
    end
    check("t6_reached_slot5", hs, 5);
    check("t6_fetch_slot5", bus.grp_ready, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("t6_after_reset");
    run_block(vecs[0], 16'h6000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
